// File: rtl/text_ram_scheduler.sv
// Character RAM for the text-mode VGA display. One RAM port is shared between
// display fetch (fixed 2-cycle latency to the font stage) and host write/clear.
module text_ram_scheduler #(
  parameter int          COLS       = 20,
  parameter int          ROWS       = 15,
  parameter int          CELL_SHIFT = 5,
  parameter logic [7:0]  CLR_CHAR   = 8'h20,
  parameter int          ADDR_W     = 9
) (
  input  logic       px_clk,
  input  logic       rst,
  input  logic       activevideo,
  input  logic [9:0] px_x,
  input  logic [9:0] px_y,
  output logic [7:0] char_out,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_col,
  input  logic [7:0] wr_row,
  input  logic [7:0] wr_char,
  output logic       wr_oor,
  input  logic       clr_start,
  output logic       busy,
  output logic       clr_done,
  output logic [1:0] dbg_state
);

  localparam int                DEPTH  = COLS * ROWS;
  localparam logic [9:0]        COLS_P = 10'(COLS);
  localparam logic [9:0]        ROWS_P = 10'(ROWS);
  localparam logic [7:0]        COLS_H = 8'(COLS);
  localparam logic [7:0]        ROWS_H = 8'(ROWS);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] w_clr_addr_nxt;
  logic              w_clr_we;

  logic [7:0]        r_mem [0:DEPTH-1];
  logic [7:0]        r_ram_q;
  logic              r_cache_vld;
  logic [ADDR_W-1:0] r_cache_addr;
  logic              r_show;
  logic [7:0]        r_char_out;
  logic              r_wr_oor;

  logic [9:0]        w_col;
  logic [9:0]        w_row;
  logic              w_disp_in;
  logic [ADDR_W-1:0] w_disp_addr;
  logic              w_disp_rd;
  logic              w_wr_oor_req;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_wr_fire;
  logic              w_we;
  logic [ADDR_W-1:0] w_we_addr;
  logic [7:0]        w_we_data;

  // Display cell lookup; a read is only spent when the pixel enters a new cell.
  assign w_col       = px_x >> CELL_SHIFT;
  assign w_row       = px_y >> CELL_SHIFT;
  assign w_disp_in   = (w_col < COLS_P) && (w_row < ROWS_P);
  assign w_disp_addr = ADDR_W'(w_row) * COLS_A + ADDR_W'(w_col);
  assign w_disp_rd   = activevideo && w_disp_in &&
                       (!r_cache_vld || (w_disp_addr != r_cache_addr));

  // Host handshake: a write transfers in the cycle where wr_valid && wr_ready;
  // wr_ready depends combinationally on this cycle's inputs and drops whenever
  // the display owns the port, the clear sequencer is active, or clr_start wins.
  assign wr_ready     = (r_state == S_IDLE) && !clr_start && !w_disp_rd;
  assign w_wr_fire    = wr_valid && wr_ready;
  assign w_wr_oor_req = (wr_col >= COLS_H) || (wr_row >= ROWS_H);
  assign w_wr_addr    = ADDR_W'(wr_row) * COLS_A + ADDR_W'(wr_col);

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_clr_we       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clr_start) begin
          w_state_nxt    = S_CLEAR;
          w_clr_addr_nxt = '0;
        end
      end
      S_CLEAR: begin
        if (!w_disp_rd) begin
          w_clr_we = 1'b1;
          if (r_clr_addr == LAST_A) begin
            w_state_nxt = S_DONE;
          end else begin
            w_clr_addr_nxt = r_clr_addr + 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge px_clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  // Writes are blocked during reset so an aborted clear stops on this exact cell.
  assign w_we      = !rst && (w_clr_we || (w_wr_fire && !w_wr_oor_req));
  assign w_we_addr = w_clr_we ? r_clr_addr : w_wr_addr;
  assign w_we_data = w_clr_we ? CLR_CHAR : wr_char;

  always_ff @(posedge px_clk) begin
    if (w_disp_rd) begin
      r_ram_q <= r_mem[w_disp_addr];
    end
    if (w_we) begin
      r_mem[w_we_addr] <= w_we_data;
    end
  end

  always_ff @(posedge px_clk) begin
    if (rst) begin
      r_cache_vld  <= 1'b0;
      r_cache_addr <= '0;
      r_show       <= 1'b0;
      r_char_out   <= 8'h00;
      r_wr_oor     <= 1'b0;
    end else begin
      if (!activevideo) begin
        r_cache_vld <= 1'b0;
      end else if (w_disp_rd) begin
        r_cache_vld  <= 1'b1;
        r_cache_addr <= w_disp_addr;
      end
      r_show     <= activevideo && w_disp_in;
      r_char_out <= r_show ? r_ram_q : 8'h00;
      r_wr_oor   <= w_wr_fire && w_wr_oor_req;
    end
  end

  assign char_out  = r_char_out;
  assign wr_oor    = r_wr_oor;
  assign busy      = (r_state == S_CLEAR);
  assign clr_done  = (r_state == S_DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_text_ram_scheduler.sv
// Bench for text_ram_scheduler: golden cell model, char_out scoreboard queue,
// table-driven port-sharing vectors and hand-written clear/reset sequences.
module tb_text_ram_scheduler;

  logic       px_clk = 1'b0;
  logic       rst;
  logic       activevideo;
  logic [9:0] px_x;
  logic [9:0] px_y;
  logic [7:0] char_out;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_col;
  logic [7:0] wr_row;
  logic [7:0] wr_char;
  logic       wr_oor;
  logic       clr_start;
  logic       busy;
  logic       clr_done;
  logic [1:0] dbg_state;

  always #5 px_clk = ~px_clk;

  text_ram_scheduler dut (
    .px_clk(px_clk), .rst(rst), .activevideo(activevideo),
    .px_x(px_x), .px_y(px_y), .char_out(char_out),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_col(wr_col),
    .wr_row(wr_row), .wr_char(wr_char), .wr_oor(wr_oor),
    .clr_start(clr_start), .busy(busy), .clr_done(clr_done),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] gold [0:299];
  logic       m_vld = 1'b0;
  int         m_addr = 0;
  logic [7:0] m_q = 8'h00;
  logic [8:0] exp_q [$];

  typedef struct {
    logic       av;
    logic [9:0] x;
    logic [9:0] y;
    logic       wv;
    logic [7:0] col;
    logic [7:0] row;
    logic [7:0] ch;
    logic       rdy;
    logic       oor;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // One clock: model the display fetch for the inputs now driven, queue the
  // expected char_out, then compare the entry queued two cycles ago.
  task automatic tick(input bit chk);
    int col, row, addr;
    logic [8:0] e;
    col  = int'(px_x) >> 5;
    row  = int'(px_y) >> 5;
    addr = row * 20 + col;
    if (rst || !activevideo) begin
      m_vld = 1'b0;
    end else if (col < 20 && row < 15 && (!m_vld || addr != m_addr)) begin
      m_vld  = 1'b1;
      m_addr = addr;
      m_q    = gold[addr];
    end
    e = {chk, (activevideo && col < 20 && row < 15) ? m_q : 8'h00};
    exp_q.push_back(e);
    @(negedge px_clk);
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      if (e[8]) check("char_out", {24'h0, char_out}, {24'h0, e[7:0]});
    end
  endtask

  task automatic put(input int i, input bit av, input int x, input int y, input bit wv,
                     input int c, input int r, input int ch, input bit rdy, input bit oor);
    vecs[i].av  = av;      vecs[i].x   = 10'(x);   vecs[i].y  = 10'(y);
    vecs[i].wv  = wv;      vecs[i].col = 8'(c);    vecs[i].row = 8'(r);
    vecs[i].ch  = 8'(ch);  vecs[i].rdy = rdy;      vecs[i].oor = oor;
  endtask

  task automatic dump();
    for (int i = 0; i < 300; i++) begin
      activevideo = 1'b1;
      px_x = 10'((i % 20) * 32);
      px_y = 10'((i / 20) * 32);
      tick(1);
    end
    activevideo = 1'b0;
    tick(1);
    tick(1);
  endtask

  initial begin
    int k;
    bit ready_bad, busy_bad, done_bad;
    int ch;

    rst = 1'b1; activevideo = 1'b0; px_x = '0; px_y = '0;
    wr_valid = 1'b0; wr_col = '0; wr_row = '0; wr_char = '0; clr_start = 1'b0;
    repeat (3) tick(0);
    rst = 1'b0;
    check("rst_char_out", {24'h0, char_out}, 32'h0);
    check("rst_wr_oor", {31'h0, wr_oor}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_clr_done", {31'h0, clr_done}, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'h0);
    check("rst_wr_ready", {31'h0, wr_ready}, 32'h1);

    // Blanking clear with a host write held and a second clr_start mid-clear.
    wr_valid = 1'b1; wr_col = 8'd3; wr_row = 8'd2; wr_char = 8'h41;
    clr_start = 1'b1;
    #1 check("clr_wins_ready", {31'h0, wr_ready}, 32'h0);
    tick(1);
    clr_start = 1'b0;
    check("clr_busy_start", {31'h0, busy}, 32'h1);
    k = 0; ready_bad = 0; busy_bad = 0;
    while (!clr_done && k < 400) begin
      clr_start = (k == 150);
      #1;
      if (wr_ready) ready_bad = 1;
      if (!busy) busy_bad = 1;
      tick(1);
      k++;
    end
    clr_start = 1'b0;
    check("clr_len_blank", 32'(k), 32'd300);
    check("clr_stall_ready", {31'h0, ready_bad}, 32'h0);
    check("clr_busy_held", {31'h0, busy_bad}, 32'h0);
    check("done_busy_low", {31'h0, busy}, 32'h0);
    check("done_ready_low", {31'h0, wr_ready}, 32'h0);
    for (int i = 0; i < 300; i++) gold[i] = 8'h20;
    tick(1);
    check("wr_after_done", {31'h0, wr_ready}, 32'h1);
    check("done_pulse", {31'h0, clr_done}, 32'h0);
    tick(1);
    gold[43] = 8'h41;
    wr_valid = 1'b0;
    tick(1);

    put(0,  0,   0,   0, 1, 20,  0, 8'h58, 1, 1);
    put(1,  0,   0,   0, 1,  0, 15, 8'h58, 1, 1);
    put(2,  0,   0,   0, 1, 19, 14, 8'h51, 1, 0);
    put(3,  1,  96,  64, 0,  0,  0, 0,     0, 0);
    put(4,  1,  97,  64, 0,  0,  0, 0,     1, 0);
    put(5,  1, 127,  95, 0,  0,  0, 0,     1, 0);
    put(6,  1, 128,  64, 0,  0,  0, 0,     0, 0);
    put(7,  1,  31,   0, 0,  0,  0, 0,     0, 0);
    put(8,  1,  32,   0, 1,  5,  0, 8'h42, 0, 0);
    put(9,  1,  33,   0, 1,  5,  0, 8'h42, 1, 0);
    put(10, 1, 160,   0, 1,  6,  0, 8'h43, 0, 0);
    put(11, 1, 161,   0, 1,  6,  0, 8'h43, 1, 0);
    put(12, 1, 100,  64, 0,  0,  0, 0,     0, 0);
    put(13, 1, 101,  64, 1,  3,  2, 8'h5a, 1, 0);
    put(14, 1, 102,  64, 0,  0,  0, 0,     1, 0);
    put(15, 0, 102,  64, 0,  0,  0, 0,     1, 0);
    put(16, 1, 102,  64, 0,  0,  0, 0,     0, 0);
    put(17, 1, 640,   0, 0,  0,  0, 0,     1, 0);
    put(18, 1,   0, 480, 0,  0,  0, 0,     1, 0);
    put(19, 1, 608, 448, 0,  0,  0, 0,     0, 0);
    put(20, 1, 639, 479, 0,  0,  0, 0,     1, 0);
    put(21, 0,   0,   0, 0,  0,  0, 0,     1, 0);

    for (int i = 0; i < 22; i++) begin
      activevideo = vecs[i].av; px_x = vecs[i].x; px_y = vecs[i].y;
      wr_valid = vecs[i].wv; wr_col = vecs[i].col; wr_row = vecs[i].row; wr_char = vecs[i].ch;
      #1 check($sformatf("wr_ready[%0d]", i), {31'h0, wr_ready}, {31'h0, vecs[i].rdy});
      tick(1);
      if (vecs[i].wv && vecs[i].rdy && vecs[i].col < 20 && vecs[i].row < 15)
        gold[int'(vecs[i].row) * 20 + int'(vecs[i].col)] = vecs[i].ch;
      check($sformatf("wr_oor[%0d]", i), {31'h0, wr_oor}, {31'h0, vecs[i].oor});
    end
    wr_valid = 1'b0; activevideo = 1'b0;
    tick(1);
    dump();

    // Clear while the display scans an active line pixel by pixel.
    activevideo = 1'b1; px_x = '0; px_y = '0;
    clr_start = 1'b1;
    tick(0);
    clr_start = 1'b0;
    k = 0;
    while (!clr_done && k < 400) begin
      px_x = 10'((k + 1) % 640);
      px_y = 10'(((k + 1) / 640) * 32);
      tick(0);
      k++;
    end
    check("clr_len_video_max", {31'h0, (k <= 312)}, 32'h1);
    check("clr_len_video_min", {31'h0, (k >= 300)}, 32'h1);
    activevideo = 1'b0;
    for (int i = 0; i < 300; i++) gold[i] = 8'h20;
    tick(1);
    tick(1);
    dump();

    // Fill with random codes, then abort a clear with reset at clr_addr 150.
    check("fill_ready", {31'h0, wr_ready}, 32'h1);
    for (int i = 0; i < 300; i++) begin
      ch = $urandom_range(0, 255);
      if (ch == 32'h20) ch = 32'h21;
      wr_valid = 1'b1; wr_col = 8'(i % 20); wr_row = 8'(i / 20); wr_char = 8'(ch);
      tick(1);
      gold[i] = 8'(ch);
    end
    wr_valid = 1'b0;
    clr_start = 1'b1;
    tick(1);
    clr_start = 1'b0;
    repeat (150) tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_state", {30'h0, dbg_state}, 32'h0);
    done_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (clr_done) done_bad = 1;
      tick(1);
    end
    check("abort_no_done", {31'h0, done_bad}, 32'h0);
    for (int i = 0; i < 150; i++) gold[i] = 8'h20;
    dump();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
